// File: rtl/clock_phase_gen_if.sv
// Control and clock-output bundle for clock_phase_gen.
// The master side is the test bench or debug logic; the slave side is the generator.
interface clock_phase_gen_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic             step;
    logic             imem_clock;
    logic             dmem_clock;
    logic             processor_clock;
    logic             regfile_clock;
    logic             step_done;
    logic             halted;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output run,
        output step,
        input  imem_clock,
        input  dmem_clock,
        input  processor_clock,
        input  regfile_clock,
        input  step_done,
        input  halted,
        input  cycle_count
    );

    modport slave (
        input  run,
        input  step,
        output imem_clock,
        output dmem_clock,
        output processor_clock,
        output regfile_clock,
        output step_done,
        output halted,
        output cycle_count
    );
endinterface

// File: rtl/clock_phase_gen.sv
// Derives imem/dmem/processor/regfile clocks as registered windows of a
// PERIOD-cycle frame, with run/halt, single-period stepping and a period counter.
module clock_phase_gen #(
    parameter int PERIOD    = 4,
    parameter int CNT_W     = 32,
    parameter int IMEM_RISE = 0,
    parameter int IMEM_FALL = 2,
    parameter int DMEM_RISE = 1,
    parameter int DMEM_FALL = 3,
    parameter int PROC_RISE = 2,
    parameter int PROC_FALL = 0,
    parameter int RF_RISE   = 2,
    parameter int RF_FALL   = 0
) (
    input  logic               clock,
    input  logic               reset,
    clock_phase_gen_if.slave   bus
);
    localparam int PHASE_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PHASE_W-1:0] LAST_PH = PHASE_W'(PERIOD - 1);

    typedef enum logic [1:0] {
        HALTED = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2
    } state_t;

    state_t             state;
    logic [PHASE_W-1:0] ph;
    logic               imem_q;
    logic               dmem_q;
    logic               proc_q;
    logic               rf_q;
    logic               step_done_q;
    logic [CNT_W-1:0]   cycle_count_q;

    // A window with rise == fall is never open; rise > fall wraps across phase 0.
    function automatic logic in_window(input int p, input int rise, input int fall);
        if (rise < fall)
            return (p >= rise) && (p < fall);
        else if (rise > fall)
            return (p >= rise) || (p < fall);
        else
            return 1'b0;
    endfunction

    function automatic logic [3:0] windows(input int p);
        return {in_window(p, IMEM_RISE, IMEM_FALL),
                in_window(p, DMEM_RISE, DMEM_FALL),
                in_window(p, PROC_RISE, PROC_FALL),
                in_window(p, RF_RISE,   RF_FALL)};
    endfunction

    // Outputs are loaded with the window of the phase that the edge moves into,
    // so every clock output is a flop with no path from run or step.
    always_ff @(posedge clock) begin
        if (reset) begin
            state                              <= HALTED;
            ph                                 <= '0;
            {imem_q, dmem_q, proc_q, rf_q}     <= 4'b0000;
            step_done_q                        <= 1'b0;
            cycle_count_q                      <= '0;
        end else begin
            step_done_q <= 1'b0;
            case (state)
                HALTED: begin
                    ph <= '0;
                    if (bus.run) begin
                        state                          <= RUN;
                        {imem_q, dmem_q, proc_q, rf_q} <= windows(0);
                    end else if (bus.step) begin
                        state                          <= STEP;
                        {imem_q, dmem_q, proc_q, rf_q} <= windows(0);
                    end else begin
                        {imem_q, dmem_q, proc_q, rf_q} <= 4'b0000;
                    end
                end
                RUN, STEP: begin
                    if (ph == LAST_PH) begin
                        ph            <= '0;
                        cycle_count_q <= cycle_count_q + CNT_W'(1);
                        if (state == RUN && bus.run) begin
                            {imem_q, dmem_q, proc_q, rf_q} <= windows(0);
                        end else begin
                            state                          <= HALTED;
                            {imem_q, dmem_q, proc_q, rf_q} <= 4'b0000;
                            step_done_q                    <= (state == STEP);
                        end
                    end else begin
                        ph                             <= ph + PHASE_W'(1);
                        {imem_q, dmem_q, proc_q, rf_q} <= windows(int'(ph) + 1);
                    end
                end
                default: begin
                    state                          <= HALTED;
                    ph                             <= '0;
                    {imem_q, dmem_q, proc_q, rf_q} <= 4'b0000;
                end
            endcase
        end
    end

    assign bus.imem_clock      = imem_q;
    assign bus.dmem_clock      = dmem_q;
    assign bus.processor_clock = proc_q;
    assign bus.regfile_clock   = rf_q;
    assign bus.step_done       = step_done_q;
    assign bus.halted          = (state == HALTED);
    assign bus.cycle_count     = cycle_count_q;

endmodule

// File: tb/tb_clock_phase_gen.sv
// Directed test of clock_phase_gen: default 4-phase frame plus a PERIOD=5,
// CNT_W=2 instance for the wrapping counter and wrapped processor window.
module tb_clock_phase_gen;
    logic clock;
    logic reset;

    int checks;
    int errors;

    clock_phase_gen_if #(.CNT_W(32)) bus_a ();
    clock_phase_gen_if #(.CNT_W(2))  bus_b ();

    clock_phase_gen dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    clock_phase_gen #(
        .PERIOD    (5),
        .CNT_W     (2),
        .PROC_RISE (3),
        .PROC_FALL (1)
    ) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected {imem, dmem, processor, regfile} for phases 0..3 of the default frame.
    logic [3:0] frame_a [4];
    // Expected processor_clock for phases 0..4 of the PERIOD=5 instance.
    logic       proc_b  [5];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_a(input string tag, input logic [3:0] clocks, input logic halted,
                           input logic step_done, input logic [31:0] count);
        check_output({tag, " clocks"}, 32'({bus_a.imem_clock, bus_a.dmem_clock,
                                            bus_a.processor_clock, bus_a.regfile_clock}), 32'(clocks));
        check_output({tag, " halted"},    32'(bus_a.halted),    32'(halted));
        check_output({tag, " step_done"}, 32'(bus_a.step_done), 32'(step_done));
        check_output({tag, " count"},     bus_a.cycle_count,    count);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        frame_a[0] = 4'b1000;
        frame_a[1] = 4'b1100;
        frame_a[2] = 4'b0111;
        frame_a[3] = 4'b0011;
        proc_b[0] = 1'b1;
        proc_b[1] = 1'b0;
        proc_b[2] = 1'b0;
        proc_b[3] = 1'b1;
        proc_b[4] = 1'b1;

        reset      = 1'b1;
        bus_a.run  = 1'b0;
        bus_a.step = 1'b0;
        bus_b.run  = 1'b0;
        bus_b.step = 1'b0;
        tick();
        tick();
        check_a("reset", 4'b0000, 1'b1, 1'b0, 32'd0);
        check_output("reset b halted", 32'(bus_b.halted), 32'd1);
        check_output("reset b count",  32'(bus_b.cycle_count), 32'd0);

        reset = 1'b0;
        tick();
        check_a("idle", 4'b0000, 1'b1, 1'b0, 32'd0);

        // Free run: window(0) appears at the edge that samples run.
        bus_a.run = 1'b1;
        for (int p = 0; p < 12; p++) begin
            tick();
            check_a($sformatf("run p%0d", p), frame_a[p % 4], 1'b0, 1'b0, 32'(p / 4));
        end
        tick();
        check_a("run 3 periods", frame_a[0], 1'b0, 1'b0, 32'd3);

        // Drop run mid-period; the period still completes.
        tick();
        check_a("stop ph1", frame_a[1], 1'b0, 1'b0, 32'd3);
        bus_a.run = 1'b0;
        tick();
        check_a("stop ph2", frame_a[2], 1'b0, 1'b0, 32'd3);
        tick();
        check_a("stop ph3", frame_a[3], 1'b0, 1'b0, 32'd3);
        tick();
        check_a("stopped", 4'b0000, 1'b1, 1'b0, 32'd4);
        tick();
        check_a("stay stopped", 4'b0000, 1'b1, 1'b0, 32'd4);

        // Single step from HALTED.
        bus_a.step = 1'b1;
        tick();
        bus_a.step = 1'b0;
        for (int p = 0; p < 4; p++) begin
            if (p > 0) tick();
            check_a($sformatf("step p%0d", p), frame_a[p], 1'b0, 1'b0, 32'd4);
        end
        tick();
        check_a("step done", 4'b0000, 1'b1, 1'b1, 32'd5);
        tick();
        check_a("step after", 4'b0000, 1'b1, 1'b0, 32'd5);

        // A step pulse while running is ignored.
        bus_a.run = 1'b1;
        tick();
        check_a("runstep ph0", frame_a[0], 1'b0, 1'b0, 32'd5);
        bus_a.step = 1'b1;
        tick();
        check_a("runstep ph1", frame_a[1], 1'b0, 1'b0, 32'd5);
        bus_a.step = 1'b0;
        bus_a.run  = 1'b0;
        tick();
        tick();
        check_a("runstep ph3", frame_a[3], 1'b0, 1'b0, 32'd5);
        tick();
        check_a("runstep end", 4'b0000, 1'b1, 1'b0, 32'd6);
        tick();
        check_a("runstep idle", 4'b0000, 1'b1, 1'b0, 32'd6);

        // run and step together: run wins, so no step_done at the boundary.
        bus_a.run  = 1'b1;
        bus_a.step = 1'b1;
        tick();
        bus_a.step = 1'b0;
        check_a("both ph0", frame_a[0], 1'b0, 1'b0, 32'd6);
        tick();
        tick();
        tick();
        check_a("both ph3", frame_a[3], 1'b0, 1'b0, 32'd6);
        tick();
        check_a("both wrap", frame_a[0], 1'b0, 1'b0, 32'd7);
        tick();
        tick();
        check_a("both ph2", frame_a[2], 1'b0, 1'b0, 32'd7);

        // Reset mid-period, then restart.
        reset = 1'b1;
        tick();
        check_a("midreset", 4'b0000, 1'b1, 1'b0, 32'd0);
        reset = 1'b0;
        for (int p = 0; p < 4; p++) begin
            tick();
            check_a($sformatf("restart p%0d", p), frame_a[p], 1'b0, 1'b0, 32'd0);
        end
        tick();
        check_a("restart wrap", frame_a[0], 1'b0, 1'b0, 32'd1);

        // PERIOD=5 instance: wrapped processor window and 2-bit counter wrap.
        bus_b.run = 1'b1;
        for (int p = 0; p < 20; p++) begin
            tick();
            check_output($sformatf("b proc p%0d", p), 32'(bus_b.processor_clock), 32'(proc_b[p % 5]));
            check_output($sformatf("b count p%0d", p), 32'(bus_b.cycle_count), 32'(p / 5));
        end
        tick();
        check_output("b count wrap", 32'(bus_b.cycle_count), 32'd0);
        check_output("b proc wrap",  32'(bus_b.processor_clock), 32'd1);
        check_output("b halted",     32'(bus_b.halted), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
